// File: rtl/galapagos_packetizer.sv
// galapagos_packetizer
//
// Purpose:
//   Sits between the FINN accelerator output stream and the single-transfer
//   AXI-stream writer that feeds the Galapagos network port. Each wide input
//   word is split into BUS_WIDTH beats, least significant beat first. Every
//   WORDS_PER_PACKET input words form one Galapagos packet. The final beat of
//   that packet carries tlast.
//
//   The writer accepts a beat when o_enable && i_idle. Its idle flag is still
//   high in the acceptance cycle, so a one-cycle GAP follows every committed
//   beat. This stops the same beat from being offered twice.
//
// Ports:
//   i_clk       clock
//   i_reset     synchronous, active-high reset
//   i_s_tvalid  input stream valid
//   o_s_tready  input stream ready (high only while IDLE)
//   i_s_tdata   input word, IN_WIDTH bits
//   o_enable    beat request to the writer
//   i_idle      writer idle flag; a beat is taken when o_enable && i_idle
//   o_data      beat data, BUS_WIDTH bits
//   o_tkeep     beat byte enables, BUS_WIDTH/8 bits
//   o_tlast     last beat of the packet
//   o_busy      high whenever the block is not IDLE
module galapagos_packetizer #(
  parameter int BUS_WIDTH        = 64,
  parameter int IN_WIDTH         = 80,
  parameter int WORDS_PER_PACKET = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_s_tvalid,
  output logic                   o_s_tready,
  input  logic [IN_WIDTH-1:0]    i_s_tdata,
  output logic                   o_enable,
  input  logic                   i_idle,
  output logic [BUS_WIDTH-1:0]   o_data,
  output logic [BUS_WIDTH/8-1:0] o_tkeep,
  output logic                   o_tlast,
  output logic                   o_busy
);

  // Derived geometry. The word register is padded up to a whole number of
  // beats so that the top beat can be sliced without running off the end.
  localparam int BEATS      = (IN_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int KEEP_W     = BUS_WIDTH / 8;
  localparam int LAST_BYTES = (IN_WIDTH / 8) - (BEATS - 1) * KEEP_W;
  localparam int WORD_W     = BEATS * BUS_WIDTH;
  localparam int IDX_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W      = (WORDS_PER_PACKET > 1) ? $clog2(WORDS_PER_PACKET) : 1;

  localparam logic [IDX_W-1:0]  LAST_BEAT = IDX_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS_PER_PACKET - 1);
  localparam logic [KEEP_W-1:0] FULL_KEEP = {KEEP_W{1'b1}};
  localparam logic [KEEP_W-1:0] LAST_KEEP = FULL_KEEP >> (KEEP_W - LAST_BYTES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic [IDX_W-1:0]  beat_idx_q,  beat_idx_d;
  logic [CNT_W-1:0]  word_cnt_q,  word_cnt_d;
  logic [WORD_W-1:0] word_q,      word_d;
  logic              word_done_q, word_done_d;

  logic                 is_send;
  logic                 is_last_beat;
  logic                 is_last_word;
  logic [BUS_WIDTH-1:0] beat_data;

  assign is_send      = (state_q == ST_SEND);
  assign is_last_beat = (beat_idx_q == LAST_BEAT);
  assign is_last_word = (word_cnt_q == LAST_WORD);

  // Next-state logic.
  // A word is captured only in IDLE.
  // In SEND, nothing moves until the writer reports idle. The beat is then
  // committed and the block always passes through GAP.
  // word_done_q tells GAP whether the committed beat finished the word.
  // It is needed because beat_idx alone cannot tell "about to send the last
  // beat" apart from "just sent it".
  always_comb begin
    state_d     = state_q;
    beat_idx_d  = beat_idx_q;
    word_cnt_d  = word_cnt_q;
    word_d      = word_q;
    word_done_d = word_done_q;

    case (state_q)
      ST_IDLE: begin
        if (i_s_tvalid) begin
          word_d      = WORD_W'(i_s_tdata);
          beat_idx_d  = '0;
          word_done_d = 1'b0;
          state_d     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (i_idle) begin
          state_d = ST_GAP;
          if (is_last_beat) begin
            word_done_d = 1'b1;
            word_cnt_d  = is_last_word ? '0 : word_cnt_q + 1'b1;
          end else begin
            beat_idx_d = beat_idx_q + 1'b1;
          end
        end
      end

      ST_GAP: begin
        state_d = word_done_q ? ST_IDLE : ST_SEND;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers. A reset mid-packet drops the partial word.
  // It also restarts packet counting, so the next accepted word is word 0
  // of a fresh packet.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      beat_idx_q  <= '0;
      word_cnt_q  <= '0;
      word_q      <= '0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_idx_q  <= beat_idx_d;
      word_cnt_q  <= word_cnt_d;
      word_q      <= word_d;
      word_done_q <= word_done_d;
    end
  end

  // Beat selection, LSB first. Bits above IN_WIDTH are the zero padding
  // loaded at capture time.
  assign beat_data = word_q[int'(beat_idx_q) * BUS_WIDTH +: BUS_WIDTH];

  // Output fields are decoded from registered state only, so they stay
  // stable for as long as the writer keeps i_idle low. They are forced to
  // zero outside SEND, which also gives the all-zero values after reset.
  assign o_s_tready = (state_q == ST_IDLE);
  assign o_enable   = is_send;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_data     = is_send ? beat_data : '0;
  assign o_tkeep    = is_send ? (is_last_beat ? LAST_KEEP : FULL_KEEP) : '0;
  assign o_tlast    = is_send && is_last_beat && is_last_word;

endmodule

// File: tb/tb_galapagos_packetizer.sv
// tb_galapagos_packetizer
//
// Purpose:
//   Self-checking bench for galapagos_packetizer with the default geometry
//   (80-bit words, 64-bit beats, 4 words per packet). The main initial block
//   drives words. Expected beats go onto a scoreboard queue as each word is
//   driven. A monitor pops and compares an entry for every beat the writer
//   would take.
module tb_galapagos_packetizer;

  logic        i_clk;
  logic        i_reset;
  logic        i_s_tvalid;
  logic        o_s_tready;
  logic [79:0] i_s_tdata;
  logic        o_enable;
  logic        i_idle;
  logic [63:0] o_data;
  logic [7:0]  o_tkeep;
  logic        o_tlast;
  logic        o_busy;

  galapagos_packetizer #(
    .BUS_WIDTH(64),
    .IN_WIDTH(80),
    .WORDS_PER_PACKET(4)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_s_tvalid(i_s_tvalid),
    .o_s_tready(o_s_tready),
    .i_s_tdata(i_s_tdata),
    .o_enable(o_enable),
    .i_idle(i_idle),
    .o_data(o_data),
    .o_tkeep(o_tkeep),
    .o_tlast(o_tlast),
    .o_busy(o_busy)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic [79:0] word;
    logic [63:0] b0;
    logic [63:0] b1;
    logic        expLast;
  } vec_t;

  beat_t expQ[$];
  vec_t  vecs[6];
  int    compared;
  int    mismatched;
  logic  randIdle;

  // Free-running clock, period 10.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Random writer pacing. When enabled, the idle flag changes just after
  // each rising edge, so it is stable at the falling-edge sample point.
  always @(posedge i_clk) begin
    #1;
    if (randIdle) i_idle = 1'($urandom_range(0, 1));
  end

  // Scoreboard monitor. A beat offered while the writer is idle is taken
  // at the next rising edge, so it is compared here on the falling edge.
  always @(negedge i_clk) begin
    if (!i_reset && o_enable && i_idle) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL beat: unexpected beat data=%h keep=%h last=%0d", o_data, o_tkeep, o_tlast);
      end else begin
        beat_t e;
        e = expQ.pop_front();
        if (o_data !== e.data || o_tkeep !== e.keep || o_tlast !== e.last) begin
          mismatched++;
          $display("[TB] FAIL beat: got data=%h keep=%h last=%0d, expected data=%h keep=%h last=%0d",
                   o_data, o_tkeep, o_tlast, e.data, e.keep, e.last);
        end
      end
    end
  end

  // Global watchdog so the run can never hang.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Generic scalar/vector comparison.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Queue the two expected beats of one word.
  task automatic pushWord(input logic [63:0] b0, input logic [63:0] b1, input logic last);
    beat_t e;
    e.data = b0; e.keep = 8'hFF; e.last = 1'b0;
    expQ.push_back(e);
    e.data = b1; e.keep = 8'h03; e.last = last;
    expQ.push_back(e);
  endtask

  // Wait (bounded) for the block to become ready. Then present one word for
  // exactly one edge. The caller must be positioned just after a rising edge.
  task automatic applyStimulus(input logic [79:0] w);
    int t;
    t = 0;
    while (!o_s_tready && t < 200) begin
      @(posedge i_clk); #1;
      t++;
    end
    if (!o_s_tready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL ready timeout: got tready=%0d, expected 1", o_s_tready);
    end
    i_s_tdata  = w;
    i_s_tvalid = 1'b1;
    @(posedge i_clk); #1;
    i_s_tvalid = 1'b0;
  endtask

  // Bounded wait until the current word has drained back to IDLE.
  task automatic waitReady(input string name);
    int t;
    t = 0;
    while (!o_s_tready && t < 500) begin
      @(posedge i_clk); #1;
      t++;
    end
    checkOutput(name, 64'(o_s_tready), 64'd1);
  endtask

  initial begin
    logic [79:0] w;
    int          pos;

    compared   = 0;
    mismatched = 0;
    randIdle   = 1'b0;
    i_idle     = 1'b1;
    i_s_tvalid = 1'b0;
    i_s_tdata  = '0;
    i_reset    = 1'b1;

    // Vector table: word, expected beat 0, expected beat 1, tlast on beat 1.
    vecs[0] = '{80'h1122_33445566778899AA, 64'h33445566778899AA, 64'h0000000000001122, 1'b0};
    vecs[1] = '{80'hFFFF_FFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h000000000000FFFF, 1'b0};
    vecs[2] = '{80'h0000_0000000000000000, 64'h0000000000000000, 64'h0000000000000000, 1'b0};
    vecs[3] = '{80'hA5A5_0123456789ABCDEF, 64'h0123456789ABCDEF, 64'h000000000000A5A5, 1'b1};
    vecs[4] = '{80'h8000_0000000000000001, 64'h0000000000000001, 64'h0000000000008000, 1'b0};
    vecs[5] = '{80'h0001_8000000000000000, 64'h8000000000000000, 64'h0000000000000001, 1'b0};

    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    // Reset/idle values.
    checkOutput("reset tready", 64'(o_s_tready), 64'd1);
    checkOutput("reset enable", 64'(o_enable),   64'd0);
    checkOutput("reset tkeep",  64'(o_tkeep),    64'd0);
    checkOutput("reset busy",   64'(o_busy),     64'd0);
    checkOutput("reset tlast",  64'(o_tlast),    64'd0);

    // Table-driven words with the writer always idle. The first word also
    // checks one-cycle latency and the GAP cycle.
    for (int i = 0; i < 6; i++) begin
      pushWord(vecs[i].b0, vecs[i].b1, vecs[i].expLast);
      applyStimulus(vecs[i].word);
      if (i == 0) begin
        checkOutput("latency enable", 64'(o_enable), 64'd1);
        checkOutput("send busy",      64'(o_busy),   64'd1);
        checkOutput("send tready",    64'(o_s_tready), 64'd0);
        @(posedge i_clk); #1;
        checkOutput("gap enable", 64'(o_enable), 64'd0);
        checkOutput("gap busy",   64'(o_busy),   64'd1);
      end
      waitReady("word drained");
    end

    // Backpressure: the writer stays busy for 5 cycles on beat 0. This is
    // the third word of the current packet, so tlast stays low.
    i_idle = 1'b0;
    pushWord(64'hCAFEBABE12345678, 64'h000000000000DEAD, 1'b0);
    applyStimulus(80'hDEAD_CAFEBABE12345678);
    for (int c = 0; c < 5; c++) begin
      checkOutput("hold data",   o_data,          64'hCAFEBABE12345678);
      checkOutput("hold tkeep",  64'(o_tkeep),    64'hFF);
      checkOutput("hold tlast",  64'(o_tlast),    64'd0);
      checkOutput("hold enable", 64'(o_enable),   64'd1);
      @(posedge i_clk); #1;
    end
    i_idle = 1'b1;
    @(posedge i_clk); #1;
    checkOutput("commit to gap", 64'(o_enable), 64'd0);
    @(posedge i_clk); #1;
    checkOutput("beat1 after hold", o_data, 64'h000000000000DEAD);
    waitReady("bp word drained");

    // Reset during beat 1 of the packet's fourth word. Beat 1 is held by a
    // busy writer, then reset is applied.
    pushWord(64'h0F0F0F0F0F0F0F0F, 64'h0000000000000BAD, 1'b1);
    applyStimulus(80'h0BAD_0F0F0F0F0F0F0F0F);
    @(posedge i_clk); #1;
    i_idle = 1'b0;
    @(posedge i_clk); #1;
    checkOutput("pre-reset beat1", o_data, 64'h0000000000000BAD);
    checkOutput("pre-reset tlast", 64'(o_tlast), 64'd1);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    checkOutput("post-reset enable", 64'(o_enable),   64'd0);
    checkOutput("post-reset tready", 64'(o_s_tready), 64'd1);
    checkOutput("post-reset busy",   64'(o_busy),     64'd0);
    checkOutput("aborted beats",     64'(expQ.size()), 64'd1);
    expQ.delete();
    i_idle = 1'b1;

    // Fresh packet: tlast only on the fourth word.
    for (int k = 0; k < 4; k++) begin
      pushWord(vecs[k].b0, vecs[k].b1, (k == 3));
      applyStimulus(vecs[k].word);
      waitReady("fresh word drained");
    end

    // Random words with random writer pacing.
    randIdle = 1'b1;
    pos = 0;
    for (int k = 0; k < 12; k++) begin
      w = {16'($urandom), $urandom, $urandom};
      pushWord(w[63:0], {48'h0, w[79:64]}, (pos == 3));
      pos = (pos + 1) % 4;
      applyStimulus(w);
      waitReady("random word drained");
    end
    randIdle = 1'b0;
    @(posedge i_clk); #1;
    i_idle = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;

    checkOutput("scoreboard empty", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
